// File: rtl/avalon_pkg.sv
// Shared Avalon-MM master definitions: FSM state encoding and width-derivation helpers.
package avalon_pkg;

    localparam int AMM_ADDR_W_DEF = 32;
    localparam int AMM_DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT_RD,
        DONE
    } amm_state_e;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // A disabled timeout (0) still needs a 1-bit counter so the design elaborates.
    function automatic int cnt_width(input int timeout_cyc);
        return (timeout_cyc < 1) ? 1 : $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/hs_amm_master.sv
// Turns one request/ack handshake transaction into a single Avalon-MM pipelined
// read or write, with a bounded wait that aborts and flags an error.
module hs_amm_master
    import avalon_pkg::*;
#(
    parameter int ADDR_W      = AMM_ADDR_W_DEF,
    parameter int DATA_W      = AMM_DATA_W_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_i,
    output logic                        ack_o,
    input  logic                        cmd_write_i,
    input  logic [ADDR_W-1:0]           cmd_addr_i,
    input  logic [DATA_W-1:0]           cmd_wrdata_i,
    input  logic [be_width(DATA_W)-1:0] cmd_byteen_i,
    output logic [DATA_W-1:0]           rsp_rddata_o,
    output logic                        rsp_error_o,
    output logic [ADDR_W-1:0]           amm_address_o,
    output logic [DATA_W-1:0]           amm_writedata_o,
    output logic [be_width(DATA_W)-1:0] amm_byteenable_o,
    output logic                        amm_read_o,
    output logic                        amm_write_o,
    input  logic                        amm_waitrequest_i,
    input  logic                        amm_readdatavalid_i,
    input  logic [DATA_W-1:0]           amm_readdata_i
);

    localparam int               BE_W       = be_width(DATA_W);
    localparam int               CNT_W      = cnt_width(TIMEOUT_CYC);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    amm_state_e        r_state;
    amm_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_writedata;
    logic [BE_W-1:0]   r_byteenable;
    logic [DATA_W-1:0] r_rddata;
    logic              r_read;
    logic              r_write;
    logic              r_error;

    logic w_busy;
    logic w_wr_done;
    logic w_rd_done;
    logic w_complete;
    logic w_timeout;

    assign w_busy     = (r_state == CMD) || (r_state == WAIT_RD);
    assign w_wr_done  = (r_state == CMD) && r_write && !amm_waitrequest_i;
    assign w_rd_done  = (r_state == WAIT_RD) && amm_readdatavalid_i;
    assign w_complete = w_wr_done || w_rd_done;
    // A read accepted on the last allowed cycle has not completed, so it still times out.
    assign w_timeout  = TIMEOUT_EN && w_busy && (r_cnt == CNT_LAST) && !w_complete;

    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (req_i) w_state_nxt = CMD;
            end
            CMD: begin
                if (w_timeout || w_wr_done) w_state_nxt = DONE;
                else if (!amm_waitrequest_i) w_state_nxt = WAIT_RD;
            end
            WAIT_RD: begin
                if (w_rd_done || w_timeout) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: command and response registers are reset too, so the bus sees all-zero fields after reset.
        if (rst_i) begin
            r_cnt        <= '0;
            r_address    <= '0;
            r_writedata  <= '0;
            r_byteenable <= '0;
            r_rddata     <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            if ((r_state == IDLE) && req_i) begin
                r_address    <= cmd_addr_i;
                r_writedata  <= cmd_wrdata_i;
                r_byteenable <= cmd_byteen_i;
                r_write      <= cmd_write_i;
                r_read       <= !cmd_write_i;
                r_error      <= 1'b0;
                r_cnt        <= '0;
            end
            if (w_busy) begin
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
                if ((r_state == CMD) && (!amm_waitrequest_i || w_timeout)) begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                end
                if (w_rd_done) r_rddata <= amm_readdata_i;
                if (w_timeout) r_error <= 1'b1;
            end
        end
    end

    assign ack_o            = (r_state == DONE);
    assign rsp_rddata_o     = r_rddata;
    assign rsp_error_o      = r_error;
    assign amm_address_o    = r_address;
    assign amm_writedata_o  = r_writedata;
    assign amm_byteenable_o = r_byteenable;
    assign amm_read_o       = r_read;
    assign amm_write_o      = r_write;

endmodule

// File: tb/tb_hs_amm_master.sv
// Self-checking bench for hs_amm_master: table-driven transactions against an
// Avalon-MM slave model, scoreboarded responses, and hand-written reset/late-response sequences.
module tb_hs_amm_master;

    localparam int TO = 8;

    logic        clk_i               = 1'b0;
    logic        rst_i               = 1'b1;
    logic        req_i               = 1'b0;
    logic        ack_o;
    logic        cmd_write_i         = 1'b0;
    logic [31:0] cmd_addr_i          = '0;
    logic [31:0] cmd_wrdata_i        = '0;
    logic [3:0]  cmd_byteen_i        = '0;
    logic [31:0] rsp_rddata_o;
    logic        rsp_error_o;
    logic [31:0] amm_address_o;
    logic [31:0] amm_writedata_o;
    logic [3:0]  amm_byteenable_o;
    logic        amm_read_o;
    logic        amm_write_o;
    logic        amm_waitrequest_i   = 1'b0;
    logic        amm_readdatavalid_i = 1'b0;
    logic [31:0] amm_readdata_i      = '0;

    always #5 clk_i = ~clk_i;

    hs_amm_master #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT_CYC(TO)
    ) u_dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .req_i              (req_i),
        .ack_o              (ack_o),
        .cmd_write_i        (cmd_write_i),
        .cmd_addr_i         (cmd_addr_i),
        .cmd_wrdata_i       (cmd_wrdata_i),
        .cmd_byteen_i       (cmd_byteen_i),
        .rsp_rddata_o       (rsp_rddata_o),
        .rsp_error_o        (rsp_error_o),
        .amm_address_o      (amm_address_o),
        .amm_writedata_o    (amm_writedata_o),
        .amm_byteenable_o   (amm_byteenable_o),
        .amm_read_o         (amm_read_o),
        .amm_write_o        (amm_write_o),
        .amm_waitrequest_i  (amm_waitrequest_i),
        .amm_readdatavalid_i(amm_readdatavalid_i),
        .amm_readdata_i     (amm_readdata_i)
    );

    // wait_n: strobe cycles with waitrequest high; rd_lat: WAIT_RD cycle carrying readdatavalid (0 = never).
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          wait_n;
        int          rd_lat;
        logic [31:0] rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_str;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rddata;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_err     = 0;
    int          n_checks  = 0;
    int          n_txn     = 0;
    int          n_ack_exp = 0;
    logic [31:0] model_rd  = '0;

    wire [103:0] all_out = {ack_o, amm_read_o, amm_write_o, rsp_error_o, rsp_rddata_o,
                            amm_address_o, amm_writedata_o, amm_byteenable_o};

    int   mon_cmds       = 0;
    int   mon_acks       = 0;
    int   mon_ack_double = 0;
    logic prev_str       = 1'b0;
    logic prev_ack       = 1'b0;

    always @(negedge clk_i) begin
        if ((amm_read_o || amm_write_o) && !prev_str) mon_cmds++;
        if (ack_o) mon_acks++;
        if (ack_o && prev_ack) mon_ack_double++;
        prev_str = amm_read_o || amm_write_o;
        prev_ack = ack_o;
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Raises req, plays the slave side cycle by cycle, and scores the ack; returns in the ack cycle.
    task automatic run_txn(input vec_t v, input string nm);
        exp_t e;
        int   cyc;
        int   str_n;
        int   k;
        bit   accepted;
        bit   done;
        @(negedge clk_i);
        cmd_write_i  = v.wr;
        cmd_addr_i   = v.addr;
        cmd_wrdata_i = v.wdata;
        cmd_byteen_i = v.be;
        req_i        = 1'b1;
        n_txn++;
        n_ack_exp++;
        if (!v.wr && !v.exp_err) model_rd = v.rdata;
        e.err    = v.exp_err;
        e.rddata = model_rd;
        e.lat    = v.exp_lat;
        sb_q.push_back(e);
        cyc = 0; str_n = 0; k = 0; accepted = 1'b0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
            amm_readdatavalid_i = 1'b0;
            amm_readdata_i      = ~v.rdata;
            if (accepted) k++;
            if (amm_read_o || amm_write_o) begin
                str_n++;
                if (str_n == 1)
                    check({nm, "_fields"},
                          128'({amm_write_o, amm_read_o, amm_address_o, amm_writedata_o, amm_byteenable_o}),
                          128'({v.wr, !v.wr, v.addr, v.wdata, v.be}));
                amm_waitrequest_i = (str_n <= v.wait_n);
                if (!amm_waitrequest_i && !v.wr) accepted = 1'b1;
            end else begin
                amm_waitrequest_i = 1'b0;
            end
            if (ack_o) begin
                done  = 1'b1;
                req_i = 1'b0;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check({nm, "_latency"}, 128'(cyc), 128'(e.lat));
                    check({nm, "_error"}, 128'(rsp_error_o), 128'(e.err));
                    check({nm, "_rddata"}, 128'(rsp_rddata_o), 128'(e.rddata));
                    check({nm, "_strobe_len"}, 128'(str_n), 128'(v.exp_str));
                end
            end else if (!v.wr && accepted && v.rd_lat > 0 && k == v.rd_lat) begin
                amm_readdatavalid_i = 1'b1;
                amm_readdata_i      = v.rdata;
            end
        end
        check({nm, "_ack_seen"}, 128'(done), 128'(1));
        if (!done) begin
            req_i = 1'b0;
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
    endtask

    initial begin
        vec_t vt[11];
        vec_t vx;
        //            wr    addr           wdata          be    wt rl rdata          err lat str
        vt[0]  = '{1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 0, 0, 32'h0,         1'b0, 2, 1};
        vt[1]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 3, 2, 32'hDEAD_BEEF, 1'b0, 7, 4};
        vt[2]  = '{1'b1, 32'h0000_1234, 32'h0,         4'h3, 1, 0, 32'h0,         1'b0, 3, 2};
        vt[3]  = '{1'b0, 32'h0000_0040, 32'h0,         4'hF, 0, 1, 32'h1234_5678, 1'b0, 3, 1};
        vt[4]  = '{1'b0, 32'h0000_0044, 32'h0,         4'hF, 0, 7, 32'hCAFE_F00D, 1'b0, 9, 1};
        vt[5]  = '{1'b0, 32'h0000_0048, 32'h0,         4'hC, 2, 5, 32'h0BAD_C0DE, 1'b0, 9, 3};
        vt[6]  = '{1'b1, 32'h0000_0050, 32'h1111_2222, 4'hF, 7, 0, 32'h0,         1'b0, 9, 8};
        vt[7]  = '{1'b1, 32'h0000_0054, 32'h3333_4444, 4'hF, 9, 0, 32'h0,         1'b1, 9, 8};
        vt[8]  = '{1'b0, 32'h0000_0058, 32'h0,         4'hF, 0, 0, 32'h7777_7777, 1'b1, 9, 1};
        vt[9]  = '{1'b1, 32'hFFFF_FFFC, 32'h0000_005A, 4'h8, 0, 0, 32'h0,         1'b0, 2, 1};
        vt[10] = '{1'b0, 32'h0000_0060, 32'h0,         4'hF, 1, 3, 32'h0,         1'b0, 6, 2};

        repeat (3) @(negedge clk_i);
        check("reset_outputs", 128'(all_out), 128'(0));
        rst_i = 1'b0;

        for (int i = 0; i < 11; i++) run_txn(vt[i], $sformatf("v%0d", i));

        // Unanswered read times out, then a late readdatavalid must be ignored.
        vx = '{1'b0, 32'h0000_0080, 32'h0, 4'hF, 0, 0, 32'h5555_5555, 1'b1, 9, 1};
        run_txn(vx, "late");
        amm_readdatavalid_i = 1'b1;
        amm_readdata_i      = 32'h1111_1111;
        repeat (3) @(negedge clk_i);
        amm_readdatavalid_i = 1'b0;
        check("late_rddata", 128'(rsp_rddata_o), 128'(model_rd));
        check("late_err_hold", 128'(rsp_error_o), 128'(1));

        // Reset pulsed while waiting for read data aborts with no ack.
        @(negedge clk_i);
        cmd_write_i = 1'b0;
        cmd_addr_i  = 32'h0000_0300;
        req_i       = 1'b1;
        n_txn++;
        @(negedge clk_i);
        check("rst_seq_strobe", 128'(amm_read_o), 128'(1));
        amm_waitrequest_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        req_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_outputs", 128'(all_out), 128'(0));
        rst_i    = 1'b0;
        model_rd = '0;

        vx = '{1'b0, 32'h0000_0304, 32'h0, 4'hF, 1, 1, 32'h600D_F00D, 1'b0, 4, 2};
        run_txn(vx, "post_rst");

        repeat (2) @(negedge clk_i);
        check("cmd_count", 128'(mon_cmds), 128'(n_txn));
        check("ack_count", 128'(mon_acks), 128'(n_ack_exp));
        check("ack_double", 128'(mon_ack_double), 128'(0));
        check("sb_empty", 128'(sb_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
